// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: collision/button events into the game sequencer and its registered
// control outputs. master = surrounding datapath, slave = game_flow_ctrl.
interface game_flow_ctrl_if;
    logic       frame_tick;
    logic       btn_start;
    logic       btn_pause;
    logic       brick_hit;
    logic       ball_miss;
    logic       max_score_reached;
    logic       score_inc;
    logic       score_clr;
    logic       ball_reset;
    logic       game_run;
    logic [2:0] lives;
    logic [1:0] text_sel;
    logic [2:0] state;

    modport master (
        output frame_tick, btn_start, btn_pause, brick_hit, ball_miss, max_score_reached,
        input  score_inc, score_clr, ball_reset, game_run, lives, text_sel, state
    );

    modport slave (
        input  frame_tick, btn_start, btn_pause, brick_hit, ball_miss, max_score_reached,
        output score_inc, score_clr, ball_reset, game_run, lives, text_sel, state
    );
endinterface

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: brick-smasher sequencer (title, serve, play, miss, win/over banners).
// Define PAUSE_EN to add the PLAY<->PAUSE toggle on btn_pause.
module game_flow_ctrl #(
    parameter int LIVES         = 3,
    parameter int SERVE_FRAMES  = 60,
    parameter int BANNER_FRAMES = 120,
    parameter int TIMER_W       = 8
) (
    input  logic            clk,
    input  logic            reset,
    game_flow_ctrl_if.slave gf
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_NEWGAME = 3'd1,
        S_SERVE   = 3'd2,
        S_PLAY    = 3'd3,
        S_MISS    = 3'd4,
        S_WIN     = 3'd5,
        S_OVER    = 3'd6,
        S_PAUSE   = 3'd7
    } state_t;

    localparam logic [TIMER_W-1:0] SERVE_LOAD  = TIMER_W'(SERVE_FRAMES);
    localparam logic [TIMER_W-1:0] BANNER_LOAD = TIMER_W'(BANNER_FRAMES);
    localparam logic [TIMER_W-1:0] TIMER_ONE   = TIMER_W'(1);
    localparam logic [2:0]         LIVES_LOAD  = 3'(LIVES);

    state_t             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [2:0]         lives_q, lives_d, lives_dec;
    logic               timer_expired;
    logic               start_armed_q, start_edge;
    logic               score_inc_q, score_clr_q, ball_reset_q, game_run_q;
    logic               score_inc_d, score_clr_d, ball_reset_d, game_run_d;
    logic [1:0]         text_sel_q, text_sel_d;

    // Arm bits hold "button was low last cycle" and reset to 0, so a button held
    // through reset must be released before it can register a press.
    assign start_edge = gf.btn_start & start_armed_q;

`ifdef PAUSE_EN
    logic pause_armed_q, pause_edge;
    assign pause_edge = gf.btn_pause & pause_armed_q;
`else
    logic unused_pause;
    assign unused_pause = gf.btn_pause;
`endif

    assign timer_expired = (timer_q == '0) || (gf.frame_tick && (timer_q == TIMER_ONE));

    // NOTE: every variable driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        lives_d   = lives_q;
        lives_dec = (lives_q == 3'd0) ? 3'd0 : lives_q - 3'd1;

        case (state_q)
            S_IDLE: if (start_edge) state_d = S_NEWGAME;
            S_NEWGAME: begin
                state_d = S_SERVE;
                lives_d = LIVES_LOAD;
                timer_d = SERVE_LOAD;
            end
            S_SERVE, S_WIN, S_OVER: begin
                if (gf.frame_tick && (timer_q != '0)) timer_d = timer_q - TIMER_ONE;
                if (timer_expired) state_d = (state_q == S_SERVE) ? S_PLAY : S_IDLE;
            end
            S_PLAY: begin
                if (gf.max_score_reached) begin
                    state_d = S_WIN;
                    timer_d = BANNER_LOAD;
                end else if (gf.ball_miss) begin
                    state_d = S_MISS;
                end
`ifdef PAUSE_EN
                else if (pause_edge) begin
                    state_d = S_PAUSE;
                end
`endif
            end
            S_MISS: begin
                lives_d = lives_dec;
                if (lives_dec == 3'd0) begin
                    state_d = S_OVER;
                    timer_d = BANNER_LOAD;
                end else begin
                    state_d = S_SERVE;
                    timer_d = SERVE_LOAD;
                end
            end
`ifdef PAUSE_EN
            S_PAUSE: begin
                if (start_edge)      state_d = S_IDLE;
                else if (pause_edge) state_d = S_PLAY;
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Pulses follow the current cycle's events; levels follow the state being entered.
        score_inc_d  = (state_q == S_PLAY) && gf.brick_hit && !gf.max_score_reached;
        score_clr_d  = (state_q == S_NEWGAME);
        ball_reset_d = 1'b1;
        game_run_d   = 1'b0;
        text_sel_d   = 2'd0;
        case (state_d)
            S_IDLE, S_NEWGAME: text_sel_d = 2'd1;
            S_PLAY: begin
                ball_reset_d = 1'b0;
                game_run_d   = 1'b1;
            end
            S_WIN:  text_sel_d = 2'd2;
            S_OVER: text_sel_d = 2'd3;
            S_PAUSE: begin
                ball_reset_d = 1'b0;
                text_sel_d   = 2'd1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            timer_q       <= '0;
            lives_q       <= 3'd0;
            start_armed_q <= 1'b0;
            score_inc_q   <= 1'b0;
            score_clr_q   <= 1'b0;
            ball_reset_q  <= 1'b1;
            game_run_q    <= 1'b0;
            text_sel_q    <= 2'd1;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            lives_q       <= lives_d;
            start_armed_q <= ~gf.btn_start;
            score_inc_q   <= score_inc_d;
            score_clr_q   <= score_clr_d;
            ball_reset_q  <= ball_reset_d;
            game_run_q    <= game_run_d;
            text_sel_q    <= text_sel_d;
        end
    end

`ifdef PAUSE_EN
    always_ff @(posedge clk) begin
        if (reset) pause_armed_q <= 1'b0;
        else       pause_armed_q <= ~gf.btn_pause;
    end
`endif

    assign gf.score_inc  = score_inc_q;
    assign gf.score_clr  = score_clr_q;
    assign gf.ball_reset = ball_reset_q;
    assign gf.game_run   = game_run_q;
    assign gf.text_sel   = text_sel_q;
    assign gf.lives      = lives_q;
    assign gf.state      = state_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb_game_flow_ctrl: three directed games with randomized frame/hit timing, checked against
// a frame-count / score / lives bookkeeping model. Build with PAUSE_EN defined to cover pause.
module tb_game_flow_ctrl;
    localparam int LIVES         = 3;
    localparam int SERVE_FRAMES  = 60;
    localparam int BANNER_FRAMES = 120;

    localparam int C_IDLE = 0, C_NEWGAME = 1, C_SERVE = 2, C_PLAY = 3;
    localparam int C_MISS = 4, C_WIN = 5, C_OVER = 6, C_PAUSE = 7;

    logic clk = 1'b0;
    logic reset;

    game_flow_ctrl_if gf ();

    game_flow_ctrl #(
        .LIVES(LIVES), .SERVE_FRAMES(SERVE_FRAMES), .BANNER_FRAMES(BANNER_FRAMES), .TIMER_W(8)
    ) dut (
        .clk(clk),
        .reset(reset),
        .gf(gf)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: totals of pulses the score counter should see, and remaining lives.
    int exp_score = 0;
    int exp_clr   = 0;
    int exp_lives = 0;
    int inc_seen  = 0;
    int clr_seen  = 0;

    always @(negedge clk) begin
        if (gf.score_inc === 1'b1) inc_seen++;
        if (gf.score_clr === 1'b1) clr_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_pass = n_pass + 1;
        else begin
            n_fail = n_fail + 1;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        repeat ($urandom_range(0, 2)) step();
        gf.frame_tick = 1'b1;
        step();
        gf.frame_tick = 1'b0;
    endtask

    task automatic start_game();
        gf.btn_start = 1'b1;
        step();
        check("newgame_state", gf.state, C_NEWGAME);
        step();
        check("serve_entry_state", gf.state, C_SERVE);
        check("score_clr_pulse", gf.score_clr, 1);
        check("lives_loaded", gf.lives, LIVES);
        exp_clr++;
        exp_lives = LIVES;
        step();
        check("score_clr_once", gf.score_clr, 0);
        check("start_hold_no_retrigger", gf.state, C_SERVE);
        gf.btn_start = 1'b0;
    endtask

    task automatic serve();
        check("serve_ball_reset", gf.ball_reset, 1);
        check("serve_game_run", gf.game_run, 0);
        check("serve_text", gf.text_sel, 0);
        gf.brick_hit = 1'b1;
        gf.ball_miss = 1'b1;
        step();
        gf.brick_hit = 1'b0;
        gf.ball_miss = 1'b0;
        check("serve_hit_ignored", gf.score_inc, 0);
        check("serve_miss_ignored", gf.state, C_SERVE);
        for (int i = 1; i <= SERVE_FRAMES; i++) begin
            pulse_tick();
            if (i == SERVE_FRAMES - 1) check("serve_hold", gf.state, C_SERVE);
        end
        check("play_state", gf.state, C_PLAY);
        check("play_game_run", gf.game_run, 1);
        check("play_ball_reset", gf.ball_reset, 0);
    endtask

    task automatic play_hits(input int n);
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin
                gf.frame_tick = 1'($urandom_range(0, 1));
                step();
            end
            gf.frame_tick = 1'b0;
            gf.brick_hit  = 1'b1;
            step();
            gf.brick_hit = 1'b0;
            check("hit_scored", gf.score_inc, 1);
            exp_score++;
            step();
            check("hit_single_pulse", gf.score_inc, 0);
            check("play_continues", gf.state, C_PLAY);
        end
    endtask

    task automatic miss(input bit with_hit);
        gf.brick_hit = with_hit;
        gf.ball_miss = 1'b1;
        step();
        gf.brick_hit = 1'b0;
        gf.ball_miss = 1'b0;
        check("miss_state", gf.state, C_MISS);
        check("miss_hit_scored", gf.score_inc, 32'(with_hit));
        check("miss_game_run", gf.game_run, 0);
        if (with_hit) exp_score++;
        exp_lives = (exp_lives > 0) ? exp_lives - 1 : 0;
        step();
        check("miss_lives", gf.lives, exp_lives);
        check("miss_exit_state", gf.state, (exp_lives == 0) ? C_OVER : C_SERVE);
    endtask

    task automatic banner(input int code, input int text);
        check("banner_state", gf.state, code);
        check("banner_text", gf.text_sel, text);
        check("banner_ball_reset", gf.ball_reset, 1);
        check("banner_game_run", gf.game_run, 0);
        gf.btn_start = 1'b1;
        step();
        check("banner_start_ignored", gf.state, code);
        gf.btn_start = 1'b0;
        step();
        for (int i = 1; i <= BANNER_FRAMES; i++) begin
            pulse_tick();
            if (i == BANNER_FRAMES - 1) check("banner_hold", gf.state, code);
        end
        check("banner_to_idle", gf.state, C_IDLE);
        check("idle_text", gf.text_sel, 1);
    endtask

    initial begin
        gf.frame_tick        = 1'b0;
        gf.btn_start         = 1'b0;
        gf.btn_pause         = 1'b0;
        gf.brick_hit         = 1'b0;
        gf.ball_miss         = 1'b0;
        gf.max_score_reached = 1'b0;
        reset                = 1'b1;
        step();
        step();
        check("rst_state", gf.state, C_IDLE);
        check("rst_lives", gf.lives, 0);
        check("rst_score_inc", gf.score_inc, 0);
        check("rst_score_clr", gf.score_clr, 0);
        check("rst_ball_reset", gf.ball_reset, 1);
        check("rst_game_run", gf.game_run, 0);
        check("rst_text", gf.text_sel, 1);
        reset = 1'b0;
        repeat (3) step();
        check("idle_after_reset", gf.state, C_IDLE);

        // Game 1: three misses (one with a simultaneous hit) end in GAME OVER.
        start_game();
        serve();
        check("play_text", gf.text_sel, 0);
        play_hits(3);
        miss(1'b0);
        serve();
        play_hits($urandom_range(1, 3));
        miss(1'b1);
        serve();
        play_hits($urandom_range(0, 2));
        miss(1'b0);
        banner(C_OVER, 3);

        // Game 2: pause handling, then a hit at max score ends in WIN.
        start_game();
        serve();
        play_hits($urandom_range(2, 5));
        gf.btn_pause = 1'b1;
        step();
`ifdef PAUSE_EN
        check("pause_state", gf.state, C_PAUSE);
        check("pause_game_run", gf.game_run, 0);
        check("pause_ball_reset", gf.ball_reset, 0);
        check("pause_text", gf.text_sel, 1);
        step();
        check("pause_hold", gf.state, C_PAUSE);
        gf.brick_hit = 1'b1;
        gf.ball_miss = 1'b1;
        step();
        gf.brick_hit = 1'b0;
        gf.ball_miss = 1'b0;
        check("pause_hit_ignored", gf.score_inc, 0);
        check("pause_miss_ignored", gf.state, C_PAUSE);
        check("pause_lives_frozen", gf.lives, exp_lives);
        gf.btn_pause = 1'b0;
        step();
        gf.btn_pause = 1'b1;
        step();
        check("resume_state", gf.state, C_PLAY);
        check("resume_game_run", gf.game_run, 1);
`else
        check("pause_ignored_state", gf.state, C_PLAY);
        check("pause_ignored_run", gf.game_run, 1);
`endif
        gf.btn_pause = 1'b0;
        step();
        gf.brick_hit         = 1'b1;
        gf.max_score_reached = 1'b1;
        step();
        gf.brick_hit = 1'b0;
        check("max_hit_suppressed", gf.score_inc, 0);
        check("win_state", gf.state, C_WIN);
        banner(C_WIN, 2);
        gf.max_score_reached = 1'b0;
        check("score_pulse_total", inc_seen, exp_score);

        // Game 3: reset in mid-serve with the start button held through release.
        start_game();
        for (int i = 0; i < SERVE_FRAMES / 2; i++) pulse_tick();
        check("mid_serve_state", gf.state, C_SERVE);
        reset        = 1'b1;
        gf.btn_start = 1'b1;
        step();
        check("mid_rst_state", gf.state, C_IDLE);
        check("mid_rst_lives", gf.lives, 0);
        check("mid_rst_game_run", gf.game_run, 0);
        check("mid_rst_ball_reset", gf.ball_reset, 1);
        check("mid_rst_text", gf.text_sel, 1);
        reset = 1'b0;
        repeat (4) step();
        check("held_start_ignored", gf.state, C_IDLE);
        gf.btn_start = 1'b0;
        step();
        gf.btn_start = 1'b1;
        step();
        check("repress_start", gf.state, C_NEWGAME);
        step();
        exp_clr++;
        gf.btn_start = 1'b0;
        step();
        check("clr_pulse_total", clr_seen, exp_clr);
        check("score_pulse_final", inc_seen, exp_score);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/game_flow_ctrl.md
Name: game_flow_ctrl

Overview:
Top-level game sequencer for the brick-smasher datapath.
- Drives the score counter (increment and clear), the ball serve/reset logic and the on-screen banner select.
- Tracks remaining lives and timed phases, counted in frames.
- Sits between the ball/brick collision logic and the score/text overlay blocks; all control outputs are registered.

Parameters:
LIVES, 3, lives loaded at new game (1..7)
SERVE_FRAMES, 60, frames ball is held before play starts
BANNER_FRAMES, 120, frames WIN/OVER banner shown before returning to IDLE
TIMER_W, 8, frame timer width; must hold max(SERVE_FRAMES, BANNER_FRAMES)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
frame_tick  in  1  one-cycle pulse per video frame
btn_start  in  1  debounced start button, level
btn_pause  in  1  debounced pause button, level (used only with PAUSE_EN)
brick_hit  in  1  one-cycle pulse per brick destroyed
ball_miss  in  1  one-cycle pulse when ball leaves bottom edge
max_score_reached  in  1  level from score counter
score_inc  out  1  one-cycle increment pulse to score counter
score_clr  out  1  one-cycle clear pulse to score counter
ball_reset  out  1  hold ball/paddle at serve position
game_run  out  1  enable ball motion
lives  out  3  remaining lives
text_sel  out  2  banner: 0 none, 1 TITLE, 2 WIN, 3 GAME OVER
state  out  3  current state code, for debug

Behaviour:
- States and codes: IDLE=0, NEWGAME=1, SERVE=2, PLAY=3, MISS=4, WIN=5, OVER=6, PAUSE=7.
- Reset (any cycle, including mid-game):
  - state=IDLE, lives=0, timer=0, btn edge registers=0.
  - score_inc=0, score_clr=0, ball_reset=1, game_run=0, text_sel=1.
- Start/pause edge detect: rising edge only (current high, previous-cycle low). Holding the button does not retrigger.
- IDLE:
  - text_sel=1, ball_reset=1.
  - Start edge -> NEWGAME.
- NEWGAME (exactly 1 cycle):
  - Next cycle: score_clr=1 for one cycle, lives=LIVES, timer=SERVE_FRAMES.
  - -> SERVE.
- SERVE:
  - ball_reset=1, game_run=0, text_sel=0.
  - Timer decrements on frame_tick.
  - frame_tick while timer==1, or timer==0 on entry -> PLAY.
- PLAY: game_run=1, ball_reset=0.
  - brick_hit -> score_inc=1 on the next cycle (latency 1).
  - score_inc is suppressed if max_score_reached is high in the same cycle, so the counter never wraps.
  - Next-state priority: max_score_reached -> WIN; else ball_miss -> MISS; else pause edge -> PAUSE (feature only).
- Simultaneous events:
  - brick_hit and ball_miss in the same cycle: hit still scored, then MISS.
  - brick_hit in the cycle of the PLAY->other transition is still scored.
- MISS (1 cycle):
  - lives decrements (saturates at 0), game_run=0.
  - New lives==0 -> OVER; else timer=SERVE_FRAMES -> SERVE.
- WIN / OVER:
  - Entry loads timer=BANNER_FRAMES; text_sel=2 (WIN) or 3 (OVER); ball_reset=1, game_run=0.
  - Decrements on frame_tick; frame_tick at timer==1 -> IDLE.
  - Start edges ignored during the banner.
- brick_hit and ball_miss are ignored outside PLAY.
- Timer arithmetic: unsigned TIMER_W bits; never decrements below 0.

Optional Feature:
PAUSE_EN
- Defined:
  - Pause edge in PLAY -> PAUSE: game_run=0, ball_reset=0, text_sel=1, hits/misses ignored, lives/timer frozen.
  - A further pause edge -> PLAY.
  - Start edge in PAUSE -> IDLE (abandon game).
- Not defined: btn_pause is ignored, state 7 is unreachable, and an illegal state code recovers to IDLE.

Test Plan:
1. Reset, then start pulse.
   - NEWGAME: score_clr high exactly 1 cycle, lives=3.
   - SERVE: ball_reset=1.
   - After 60 frame_ticks: state=3, game_run=1.
2. In PLAY, 3 brick_hit pulses.
   - 3 score_inc pulses, each 1 cycle after its hit.
   - Hit with max_score_reached=1: no score_inc, state=5, text_sel=2; IDLE after 120 frame_ticks.
3. Three ball_miss events, one per PLAY phase.
   - Lives sequence 2,1,0.
   - Third miss -> OVER, text_sel=3.
   - Start edges during the banner are ignored.
4. brick_hit and ball_miss in the same cycle.
   - score_inc pulses once, lives decrements, state goes to SERVE.
5. Reset asserted mid-SERVE with timer=30.
   - Next cycle: state=0, lives=0, game_run=0, text_sel=1.
   - btn_start held high through reset release: no start until the button is released and pressed again.
6. PAUSE_EN defined, pause edge in PLAY.
   - state=7, game_run=0; brick_hit not scored.
   - Second pause edge returns to PLAY.
   - PAUSE_EN undefined: pause edge leaves the state at 3.
